program_counter_seq: RTL and testbench
======================================

Name: program_counter_seq

Overview:
- Parametrised successor to the core's program counter unit. Holds the fetch PC and selects the next PC from five sources: sequential increment, branch/jump redirect, trap entry, trap return and hold.
- Adds stall, a halt/resume FSM, a boot state that presents the reset vector, and redirect-target misalignment detection.
- Sits between the execute/trap logic and the instruction fetch port of the single-cycle core.

Parameters:
- DWIDTH, 32: PC width in bits.
- RESET_VECTOR, 32'h0000_0000: PC value loaded by reset.
- INCR, 4: sequential increment in bytes.
- IALIGN, 4: required target alignment in bytes. Must be a power of 2 and ≤ INCR.

Ports:
- Clk_Core  input  1  core clock
- Rst_Core_N  input  1  asynchronous active-low reset
- Stall  input  1  hold the current PC
- Branch_Taken  input  1  redirect to Branch_Target
- Branch_Target  input  DWIDTH  branch/jump target address
- Trap_Req  input  1  enter trap handler
- Trap_Vector  input  DWIDTH  trap handler address; low log2(IALIGN) bits are forced to 0
- Trap_Ret  input  1  return from trap
- Trap_Ret_Addr  input  DWIDTH  return address (mepc)
- Halt_Req  input  1  request halt
- Resume_Req  input  1  leave halt
- Program_Count  output  DWIDTH  current PC
- Program_Count_Off  output  DWIDTH  Program_Count + INCR
- PC_Valid  output  1  Program_Count is a valid fetch address
- Misalign_Err  output  1  single-cycle pulse: misaligned redirect was rejected
- Misalign_Addr  output  DWIDTH  the offending target
- PC_State  output  2  FSM state: 0 BOOT, 1 RUN, 2 HALT

Behaviour:
- Reset (asynchronous, Rst_Core_N=0):
  - Program_Count=RESET_VECTOR, state=BOOT, PC_Valid=0.
  - Misalign_Err=0, Misalign_Addr=0.
  - Reset asserted mid-operation aborts any pending redirect immediately.
- BOOT:
  - Lasts exactly one cycle after reset release. PC is held and all inputs are ignored.
  - Next state is RUN. PC_Valid=1 from the first RUN cycle.
- RUN: next-PC priority, registered on the next clock edge:
  - Trap_Req: PC := Trap_Vector & ~(IALIGN-1).
  - else Trap_Ret: PC := Trap_Ret_Addr.
  - else Branch_Taken: PC := Branch_Target.
  - else Halt_Req: PC holds, state := HALT.
  - else Stall: PC holds.
  - else PC := PC + INCR.
- Trap, trap-return and branch override both Stall and Halt_Req. A simultaneous Halt_Req is dropped; the requester must re-assert it.
- Alignment check, applied to Trap_Ret_Addr and Branch_Target only when that source is selected:
  - If target[log2(IALIGN)-1:0] != 0, the redirect is rejected and PC holds.
  - Misalign_Err=1 for the following cycle only. Misalign_Addr is loaded with the target and holds until the next error.
  - The rejected redirect is not replaced by a lower-priority source.
- HALT:
  - PC_Valid=0; PC holds; Stall and Branch_Taken are ignored.
  - Trap_Req: PC := aligned Trap_Vector, state := RUN (trap wakes the core).
  - else Resume_Req: state := RUN, PC unchanged; PC_Valid=1 the next cycle.
  - Trap_Ret in HALT is ignored.
- Arithmetic: Program_Count_Off = Program_Count + INCR, combinational, modulo 2^DWIDTH. PC wraps from 2^DWIDTH-INCR to 0 with no error.
- Latency: each selection takes effect one clock after the inputs are sampled. The outputs Program_Count, PC_Valid and PC_State are registered.

Decomposition:
- Package pc_pkg holds:
  - pc_state_e {PC_BOOT=2'd0, PC_RUN=2'd1, PC_HALT=2'd2}
  - pc_src_e {SRC_INCR, SRC_BRANCH, SRC_TRAP, SRC_TRET, SRC_HOLD}
- One sub-module, pc_next_sel, is combinational: priority encoding to pc_src_e, target mux, alignment check and misalign flag.
- The top level holds the FSM, the PC register and the error registers.

Test Plan:
- Reset release with RESET_VECTOR=32'h100: BOOT for 1 cycle -> Program_Count 0x100, 0x104, 0x108; PC_Valid rises on the first RUN cycle; Program_Count_Off=0x104 while PC=0x100.
- Stall held 3 cycles at PC=0x108, then Branch_Taken=1 with Stall=1 and target 0x200 -> PC held at 0x108 for 3 cycles, then 0x200 on the following cycle.
- Trap_Req, Trap_Ret and Branch_Taken asserted together; Trap_Vector=0x803, Trap_Ret_Addr=0x400 -> PC=0x800. Next cycle Trap_Ret alone -> PC=0x400.
- Branch_Taken with Branch_Target=0x202 (IALIGN=4) at PC=0x300 -> PC stays 0x300; Misalign_Err=1 for exactly 1 cycle; Misalign_Addr=0x202.
- Halt_Req at PC=0x500 -> HALT, PC_Valid=0, PC stays 0x500. Resume_Req -> RUN, then PC 0x500, 0x504. A second halt woken by Trap_Req with Trap_Vector=0x900 -> RUN, PC=0x900.
- PC=32'hFFFF_FFFC incrementing -> next PC=0, Program_Count_Off=0 at the wrap. Asserting Rst_Core_N=0 mid-stream -> PC=RESET_VECTOR asynchronously.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types for the program counter sequencer: FSM states and next-PC sources.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_BOOT = 2'd0,
        PC_RUN  = 2'd1,
        PC_HALT = 2'd2
    } pc_state_e;

    typedef enum logic [2:0] {
        SRC_INCR,
        SRC_BRANCH,
        SRC_TRAP,
        SRC_TRET,
        SRC_HOLD
    } pc_src_e;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC source selection, target mux and redirect alignment check.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned IALIGN = 4
) (
    input  pc_state_e         state_i,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic [DWIDTH-1:0] branch_target_i,
    input  logic              trap_req_i,
    input  logic [DWIDTH-1:0] trap_vector_i,
    input  logic              trap_ret_i,
    input  logic [DWIDTH-1:0] trap_ret_addr_i,
    input  logic              halt_req_i,
    output pc_src_e           src_o,
    output logic [DWIDTH-1:0] target_o,
    output logic              halt_o,
    output logic              misalign_o
);

    localparam logic [DWIDTH-1:0] ALIGN_MASK = DWIDTH'(IALIGN - 1);

    // Priority encode the active source; only RUN honours the full set, HALT only wakes on trap.
    always_comb begin
        src_o    = SRC_HOLD;
        target_o = '0;
        halt_o   = 1'b0;
        unique case (state_i)
            PC_RUN: begin
                if (trap_req_i) begin
                    src_o    = SRC_TRAP;
                    target_o = trap_vector_i & ~ALIGN_MASK;
                end else if (trap_ret_i) begin
                    src_o    = SRC_TRET;
                    target_o = trap_ret_addr_i;
                end else if (branch_taken_i) begin
                    src_o    = SRC_BRANCH;
                    target_o = branch_target_i;
                end else if (halt_req_i) begin
                    halt_o   = 1'b1;
                end else if (!stall_i) begin
                    src_o    = SRC_INCR;
                end
            end
            PC_HALT: begin
                if (trap_req_i) begin
                    src_o    = SRC_TRAP;
                    target_o = trap_vector_i & ~ALIGN_MASK;
                end
            end
            default: ;
        endcase
    end

    // Trap vectors are force-aligned above, so only branch and trap-return targets can fault.
    always_comb begin
        misalign_o = ((src_o == SRC_BRANCH) || (src_o == SRC_TRET)) &&
                     ((target_o & ALIGN_MASK) != '0);
    end

endmodule

// File: rtl/program_counter_seq.sv
// Fetch program counter with boot/run/halt FSM, prioritised redirects and misalignment reporting.
module program_counter_seq
    import pc_pkg::*;
#(
    parameter int unsigned       DWIDTH       = 32,
    parameter logic [DWIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned       INCR         = 4,
    parameter int unsigned       IALIGN       = 4
) (
    input  logic              Clk_Core,
    input  logic              Rst_Core_N,
    input  logic              Stall,
    input  logic              Branch_Taken,
    input  logic [DWIDTH-1:0] Branch_Target,
    input  logic              Trap_Req,
    input  logic [DWIDTH-1:0] Trap_Vector,
    input  logic              Trap_Ret,
    input  logic [DWIDTH-1:0] Trap_Ret_Addr,
    input  logic              Halt_Req,
    input  logic              Resume_Req,
    output logic [DWIDTH-1:0] Program_Count,
    output logic [DWIDTH-1:0] Program_Count_Off,
    output logic              PC_Valid,
    output logic              Misalign_Err,
    output logic [DWIDTH-1:0] Misalign_Addr,
    output logic [1:0]        PC_State
);

    pc_state_e         state_q, state_d;
    logic [DWIDTH-1:0] pc_q, pc_d;
    logic              valid_q;
    logic              err_q;
    logic [DWIDTH-1:0] err_addr_q;

    pc_src_e           src;
    logic [DWIDTH-1:0] target;
    logic              halt_sel;
    logic              misalign;

    pc_next_sel #(
        .DWIDTH (DWIDTH),
        .IALIGN (IALIGN)
    ) u_next_sel (
        .state_i         (state_q),
        .stall_i         (Stall),
        .branch_taken_i  (Branch_Taken),
        .branch_target_i (Branch_Target),
        .trap_req_i      (Trap_Req),
        .trap_vector_i   (Trap_Vector),
        .trap_ret_i      (Trap_Ret),
        .trap_ret_addr_i (Trap_Ret_Addr),
        .halt_req_i      (Halt_Req),
        .src_o           (src),
        .target_o        (target),
        .halt_o          (halt_sel),
        .misalign_o      (misalign)
    );

    // Next state and next PC; a rejected redirect holds rather than falling through to a lower source.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            PC_BOOT: state_d = PC_RUN;
            PC_RUN:  if (halt_sel) state_d = PC_HALT;
            PC_HALT: if (src == SRC_TRAP || Resume_Req) state_d = PC_RUN;
            default: state_d = PC_BOOT;
        endcase
        unique case (src)
            SRC_INCR:              pc_d = pc_q + DWIDTH'(INCR);
            SRC_TRAP:              pc_d = target;
            SRC_BRANCH, SRC_TRET:  if (!misalign) pc_d = target;
            default: ;
        endcase
    end

    // PC, FSM and valid flag registers.
    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N) begin
            state_q <= PC_BOOT;
            pc_q    <= RESET_VECTOR;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= (state_d == PC_RUN);
        end
    end

    // Misalignment pulse and sticky offending address.
    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            err_q <= misalign;
            if (misalign) err_addr_q <= target;
        end
    end

    assign Program_Count     = pc_q;
    assign Program_Count_Off = pc_q + DWIDTH'(INCR);
    assign PC_Valid          = valid_q;
    assign Misalign_Err      = err_q;
    assign Misalign_Addr     = err_addr_q;
    assign PC_State          = state_q;

endmodule

// File: tb/tb_program_counter_seq.sv
// Randomised and directed bench for program_counter_seq against a behavioural model.
module tb_program_counter_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, br, trap, tret, halt, resume;
    logic [31:0] bt, tv, tra;
    logic [31:0] pc, pc_off, err_addr;
    logic        valid, err;
    logic [1:0]  st;

    int unsigned vec  = 0;
    int unsigned miss = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_addr;
    int          m_st;   // 0 boot, 1 run, 2 halt
    logic        m_err;

    always #5 clk = ~clk;

    program_counter_seq #(
        .DWIDTH       (32),
        .RESET_VECTOR (32'h100),
        .INCR         (4),
        .IALIGN       (4)
    ) dut (
        .Clk_Core          (clk),
        .Rst_Core_N        (rst_n),
        .Stall             (stall),
        .Branch_Taken      (br),
        .Branch_Target     (bt),
        .Trap_Req          (trap),
        .Trap_Vector       (tv),
        .Trap_Ret          (tret),
        .Trap_Ret_Addr     (tra),
        .Halt_Req          (halt),
        .Resume_Req        (resume),
        .Program_Count     (pc),
        .Program_Count_Off (pc_off),
        .PC_Valid          (valid),
        .Misalign_Err      (err),
        .Misalign_Addr     (err_addr),
        .PC_State          (st)
    );

    task automatic clear_inputs();
        stall = 0; br = 0; trap = 0; tret = 0; halt = 0; resume = 0;
        bt = '0; tv = '0; tra = '0;
    endtask

    task automatic model_reset();
        m_pc = 32'h100; m_st = 0; m_err = 0; m_addr = '0;
    endtask

    // Advance one clock: model computes from the inputs seen at the edge, outputs sampled #1 later.
    task automatic tick();
        logic [31:0] n_pc, n_addr, tgt;
        int          n_st;
        logic        n_err;
        n_pc = m_pc; n_st = m_st; n_err = 0; n_addr = m_addr;
        if (m_st == 0) begin
            n_st = 1;
        end else if (m_st == 1) begin
            if (trap) n_pc = tv & 32'hFFFF_FFFC;
            else if (tret || br) begin
                tgt = tret ? tra : bt;
                if (tgt % 4 != 0) begin n_err = 1; n_addr = tgt; end
                else n_pc = tgt;
            end
            else if (halt) n_st = 2;
            else if (!stall) n_pc = m_pc + 32'd4;
        end else begin
            if (trap) begin n_pc = tv & 32'hFFFF_FFFC; n_st = 1; end
            else if (resume) n_st = 1;
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_st = n_st; m_err = n_err; m_addr = n_addr;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        model_reset();
        #12;
        vec++;
        if (pc !== 32'h100 || valid !== 1'b0 || st !== 2'd0 || err !== 1'b0 || err_addr !== 32'h0) begin
            miss++;
            $display("FAIL reset_state pc=%h valid=%b st=%0d err=%b addr=%h, expected 100/0/0/0/0", pc, valid, st, err, err_addr);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        #2;
        vec++;
        if (st !== 2'd0 || valid !== 1'b0 || pc !== 32'h100) begin
            miss++;
            $display("FAIL boot_state st=%0d valid=%b pc=%h, expected 0/0/100", st, valid, pc);
        end
    endtask

    task automatic test_boot_sequence();
        tick();
        vec++;
        if (st !== 2'd1 || valid !== 1'b1 || pc !== 32'h100 || pc_off !== 32'h104) begin
            miss++;
            $display("FAIL boot_to_run st=%0d valid=%b pc=%h off=%h, expected 1/1/100/104", st, valid, pc, pc_off);
        end
        tick();
        vec++;
        if (pc !== 32'h104) begin miss++; $display("FAIL incr1 pc=%h expected 104", pc); end
        tick();
        vec++;
        if (pc !== 32'h108) begin miss++; $display("FAIL incr2 pc=%h expected 108", pc); end
    endtask

    task automatic test_stall_branch();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vec++;
            if (pc !== 32'h108) begin miss++; $display("FAIL stall_hold%0d pc=%h expected 108", i, pc); end
        end
        br = 1; bt = 32'h200;
        tick();
        vec++;
        if (pc !== 32'h200) begin miss++; $display("FAIL branch_over_stall pc=%h expected 200", pc); end
        clear_inputs();
    endtask

    task automatic test_trap_priority();
        trap = 1; tret = 1; br = 1; tv = 32'h803; tra = 32'h400; bt = 32'h600;
        tick();
        vec++;
        if (pc !== 32'h800) begin miss++; $display("FAIL trap_priority pc=%h expected 800", pc); end
        clear_inputs();
        tret = 1; tra = 32'h400;
        tick();
        vec++;
        if (pc !== 32'h400) begin miss++; $display("FAIL trap_return pc=%h expected 400", pc); end
        clear_inputs();
    endtask

    task automatic test_misalign();
        br = 1; bt = 32'h300;
        tick();
        bt = 32'h202;
        tick();
        vec++;
        if (pc !== 32'h300 || err !== 1'b1 || err_addr !== 32'h202) begin
            miss++;
            $display("FAIL misalign_reject pc=%h err=%b addr=%h, expected 300/1/202", pc, err, err_addr);
        end
        clear_inputs();
        tick();
        vec++;
        if (pc !== 32'h304 || err !== 1'b0 || err_addr !== 32'h202) begin
            miss++;
            $display("FAIL misalign_pulse pc=%h err=%b addr=%h, expected 304/0/202", pc, err, err_addr);
        end
    endtask

    task automatic test_halt_resume();
        br = 1; bt = 32'h500;
        tick();
        clear_inputs();
        halt = 1;
        tick();
        vec++;
        if (st !== 2'd2 || valid !== 1'b0 || pc !== 32'h500) begin
            miss++;
            $display("FAIL halt_enter st=%0d valid=%b pc=%h, expected 2/0/500", st, valid, pc);
        end
        clear_inputs();
        br = 1; bt = 32'h700; tret = 1; tra = 32'h740; stall = 1;
        tick();
        vec++;
        if (st !== 2'd2 || pc !== 32'h500 || err !== 1'b0) begin
            miss++;
            $display("FAIL halt_ignores st=%0d pc=%h err=%b, expected 2/500/0", st, pc, err);
        end
        clear_inputs();
        resume = 1;
        tick();
        vec++;
        if (st !== 2'd1 || valid !== 1'b1 || pc !== 32'h500) begin
            miss++;
            $display("FAIL resume st=%0d valid=%b pc=%h, expected 1/1/500", st, valid, pc);
        end
        clear_inputs();
        tick();
        vec++;
        if (pc !== 32'h504) begin miss++; $display("FAIL after_resume pc=%h expected 504", pc); end
        halt = 1;
        tick();
        clear_inputs();
        trap = 1; tv = 32'h900;
        tick();
        vec++;
        if (st !== 2'd1 || valid !== 1'b1 || pc !== 32'h900) begin
            miss++;
            $display("FAIL trap_wake st=%0d valid=%b pc=%h, expected 1/1/900", st, valid, pc);
        end
        clear_inputs();
    endtask

    task automatic test_wrap();
        br = 1; bt = 32'hFFFF_FFFC;
        tick();
        clear_inputs();
        vec++;
        if (pc !== 32'hFFFF_FFFC || pc_off !== 32'h0) begin
            miss++;
            $display("FAIL wrap_off pc=%h off=%h, expected fffffffc/0", pc, pc_off);
        end
        tick();
        vec++;
        if (pc !== 32'h0 || pc_off !== 32'h4 || err !== 1'b0) begin
            miss++;
            $display("FAIL wrap_pc pc=%h off=%h err=%b, expected 0/4/0", pc, pc_off, err);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            trap   = ($urandom_range(15) == 0);
            tret   = ($urandom_range(15) == 0);
            br     = ($urandom_range(5) == 0);
            halt   = ($urandom_range(11) == 0);
            stall  = ($urandom_range(3) == 0);
            resume = ($urandom_range(2) == 0);
            tv  = $urandom;
            tra = $urandom;
            bt  = $urandom;
            if ($urandom_range(3) != 0) tra[1:0] = 2'b00;
            if ($urandom_range(3) != 0) bt[1:0]  = 2'b00;
            tick();
            vec++;
            if (pc !== m_pc || pc_off !== m_pc + 32'd4 || valid !== (m_st == 1) ||
                st !== 2'(m_st) || err !== m_err || err_addr !== m_addr) begin
                miss++;
                $display("FAIL random cyc=%0d pc=%h/%h st=%0d/%0d valid=%b err=%b/%b addr=%h/%h",
                         c, pc, m_pc, st, m_st, valid, err, m_err, err_addr, m_addr);
            end
        end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        #3;
        br = 1; bt = 32'h40;
        rst_n = 0;
        #1;
        vec++;
        if (pc !== 32'h100 || st !== 2'd0 || valid !== 1'b0 || err !== 1'b0 || err_addr !== 32'h0) begin
            miss++;
            $display("FAIL async_reset pc=%h st=%0d valid=%b err=%b addr=%h, expected 100/0/0/0/0", pc, st, valid, err, err_addr);
        end
        @(posedge clk);
        #1;
        vec++;
        if (pc !== 32'h100) begin miss++; $display("FAIL reset_abort pc=%h expected 100", pc); end
        clear_inputs();
        rst_n = 1;
        model_reset();
        tick();
        vec++;
        if (st !== 2'd1 || pc !== 32'h100 || valid !== 1'b1) begin
            miss++;
            $display("FAIL post_reset st=%0d pc=%h valid=%b, expected 1/100/1", st, pc, valid);
        end
    endtask

    initial begin
        test_reset();
        test_boot_sequence();
        test_stall_branch();
        test_trap_priority();
        test_misalign();
        test_halt_resume();
        test_wrap();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
